// File: rtl/ahb_master_bridge_pkg.sv
// Shared types, constants and data-path helpers for the AHB-Lite master bridge.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    DATA     = 3'd2,
    RESP     = 3'd3,
    ERR_RESP = 3'd4
  } bridge_state_t;

  // Pick the addressed lane and zero/sign-extend it to 32 bits.
  function automatic logic [31:0] rd_extend(input logic [31:0] data, input logic [1:0] lane,
                                            input logic [2:0] size, input logic sgn);
    logic [31:0] sh;
    logic [31:0] res;
    sh = data >> {lane, 3'b000};
    case (size)
      HSIZE_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
      HSIZE_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
      default:    res = data;
    endcase
    return res;
  endfunction

  // Replicate LSB-justified store data onto every byte lane it may occupy.
  function automatic logic [31:0] wr_replicate(input logic [31:0] data, input logic [2:0] size);
    logic [31:0] res;
    case (size)
      HSIZE_BYTE: res = {4{data[7:0]}};
      HSIZE_HALF: res = {2{data[15:0]}};
      default:    res = data;
    endcase
    return res;
  endfunction

  // Sizes above word are treated as misaligned so they take the error path.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    logic res;
    case (size)
      HSIZE_BYTE: res = 1'b0;
      HSIZE_HALF: res = addr_lo[0];
      HSIZE_WORD: res = (addr_lo != 2'b00);
      default:    res = 1'b1;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ahb_master_bridge_if.sv
// Core request/response and AHB-Lite bus signals of the master bridge.
interface ahb_master_bridge_if;
  import ahb_pkg::*;

  logic        req_valid;
  logic        req_write;
  logic        req_fetch;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        req_signed;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        HSEL1;
  logic        HSEL2;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic        is_signed;
  htrans_t     htrans;
  logic [31:0] hwdata;
  logic [31:0] instruction;
  logic [31:0] load_out;
  logic        hready_inst;
  logic        hready_data;
  logic        hresp_inst;
  logic        hresp_data;

  modport master (
    input  req_valid, req_write, req_fetch, req_addr, req_wdata, req_size, req_signed,
    input  instruction, load_out, hready_inst, hready_data, hresp_inst, hresp_data,
    output busy, resp_valid, resp_rdata, resp_err,
    output HSEL1, HSEL2, haddr, hwrite, hsize, hprot, is_signed, htrans, hwdata
  );

  modport slave (
    output req_valid, req_write, req_fetch, req_addr, req_wdata, req_size, req_signed,
    output instruction, load_out, hready_inst, hready_data, hresp_inst, hresp_data,
    input  busy, resp_valid, resp_rdata, resp_err,
    input  HSEL1, HSEL2, haddr, hwrite, hsize, hprot, is_signed, htrans, hwdata
  );
endinterface

// File: rtl/ahb_master_bridge_decoder.sv
// Combinational address decoder: ROM/RAM window match and write-protect check.
module ahb_addr_decoder #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter logic [31:0] ROM_MASK = 32'hFFFF_F000,
  parameter logic [31:0] RAM_BASE = 32'h1000_0000,
  parameter logic [31:0] RAM_MASK = 32'hFFFF_F000
) (
  input  logic [31:0] addr_i,
  input  logic        write_i,
  output logic        sel_rom_o,
  output logic        sel_ram_o,
  output logic        unmapped_o,
  output logic        ro_violation_o
);
  assign sel_rom_o      = ((addr_i & ROM_MASK) == ROM_BASE);
  assign sel_ram_o      = ((addr_i & RAM_MASK) == RAM_BASE) & ~sel_rom_o;
  assign unmapped_o     = ~sel_rom_o & ~sel_ram_o;
  assign ro_violation_o = sel_rom_o & write_i;
endmodule

// File: rtl/ahb_master_bridge.sv
// AHB-Lite master bridge: one core request -> one AHB transfer to ROM (HSEL1)
// or RAM (HSEL2). Optional DATA-phase timeout under macro AHB_BRIDGE_TIMEOUT_EN.
module ahb_master_bridge
  import ahb_pkg::*;
#(
  parameter logic [31:0] ROM_BASE    = 32'h0000_0000,
  parameter logic [31:0] ROM_MASK    = 32'hFFFF_F000,
  parameter logic [31:0] RAM_BASE    = 32'h1000_0000,
  parameter logic [31:0] RAM_MASK    = 32'hFFFF_F000,
  parameter int          TIMEOUT_CYC = 16
) (
  input logic               clk,
  input logic               reset,
  ahb_master_bridge_if.master bus
);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [2:0]    size_q, size_d;
  logic          write_q, write_d, fetch_q, fetch_d, signed_q, signed_d;
  logic          rom_q, rom_d, ram_q, ram_d, err_q, err_d;
  // ERR_RESP spends one silent cycle first so error completions land in the
  // same slot as an address-phase-only bus transfer would.
  logic          err_ph_q, err_ph_d;
`ifdef AHB_BRIDGE_TIMEOUT_EN
  logic [15:0]   cnt_q, cnt_d;
`endif

  logic eff_write_s, sel_rom_s, sel_ram_s, unmapped_s, ro_viol_s, hready_s, hresp_s;

  // A fetch is always a read regardless of req_write.
  assign eff_write_s = bus.req_write & ~bus.req_fetch;
  assign hready_s    = rom_q ? bus.hready_inst : bus.hready_data;
  assign hresp_s     = rom_q ? bus.hresp_inst  : bus.hresp_data;

  ahb_addr_decoder #(
    .ROM_BASE(ROM_BASE), .ROM_MASK(ROM_MASK), .RAM_BASE(RAM_BASE), .RAM_MASK(RAM_MASK)
  ) u_dec (
    .addr_i(bus.req_addr), .write_i(eff_write_s), .sel_rom_o(sel_rom_s),
    .sel_ram_o(sel_ram_s), .unmapped_o(unmapped_s), .ro_violation_o(ro_viol_s)
  );

  // State, request latch and captured response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
      fetch_q  <= 1'b0;
      signed_q <= 1'b0;
      rom_q    <= 1'b0;
      ram_q    <= 1'b0;
      err_q    <= 1'b0;
      err_ph_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      size_q   <= size_d;
      write_q  <= write_d;
      fetch_q  <= fetch_d;
      signed_q <= signed_d;
      rom_q    <= rom_d;
      ram_q    <= ram_d;
      err_q    <= err_d;
      err_ph_q <= err_ph_d;
    end
  end

`ifdef AHB_BRIDGE_TIMEOUT_EN
  // Wait-state counter for the DATA-phase timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next-state logic: accept/decode in IDLE, wait for hready in DATA.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    size_d   = size_q;
    write_d  = write_q;
    fetch_d  = fetch_q;
    signed_d = signed_q;
    rom_d    = rom_q;
    ram_d    = ram_q;
    err_d    = err_q;
    err_ph_d = err_ph_q;
`ifdef AHB_BRIDGE_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          size_d   = bus.req_size;
          write_d  = eff_write_s;
          fetch_d  = bus.req_fetch;
          signed_d = bus.req_signed;
          rom_d    = sel_rom_s;
          ram_d    = sel_ram_s;
          err_d    = 1'b0;
          err_ph_d = 1'b0;
          if (unmapped_s || ro_viol_s || is_misaligned(bus.req_addr[1:0], bus.req_size)) begin
            state_d = ERR_RESP;
          end else begin
            state_d = ADDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        state_d = DATA;
`ifdef AHB_BRIDGE_TIMEOUT_EN
        cnt_d   = 16'd0;
`endif
      end
      DATA: begin
        if (hready_s) begin
          rdata_d = rom_q ? bus.instruction : bus.load_out;
          err_d   = hresp_s;
          state_d = RESP;
        end else begin
`ifdef AHB_BRIDGE_TIMEOUT_EN
          if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = cnt_q + 16'd1;
          end
`else
          state_d = DATA;
`endif
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      ERR_RESP: begin
        if (err_ph_q) begin
          err_ph_d = 1'b0;
          state_d  = IDLE;
        end else begin
          err_ph_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state and latched request only.
  always_comb begin
    bus.busy       = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.resp_err   = 1'b0;
    bus.HSEL1      = 1'b0;
    bus.HSEL2      = 1'b0;
    bus.haddr      = 32'd0;
    bus.hwrite     = 1'b0;
    bus.hsize      = 3'd0;
    bus.hprot      = 4'd0;
    bus.is_signed  = 1'b0;
    bus.htrans     = HTRANS_IDLE;
    bus.hwdata     = 32'd0;
    case (state_q)
      ADDR, DATA: begin
        bus.busy      = 1'b1;
        bus.HSEL1     = rom_q;
        bus.HSEL2     = ram_q;
        bus.haddr     = addr_q;
        bus.hwrite    = write_q;
        bus.hsize     = size_q;
        bus.hprot     = {3'b001, ~fetch_q};
        bus.is_signed = signed_q;
        if (state_q == ADDR) begin
          bus.htrans = HTRANS_NONSEQ;
        end else begin
          bus.hwdata = write_q ? wr_replicate(wdata_q, size_q) : 32'd0;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        bus.resp_rdata = (err_q || write_q) ? 32'd0 : rd_extend(rdata_q, addr_q[1:0], size_q, signed_q);
      end
      ERR_RESP: begin
        bus.busy       = ~err_ph_q;
        bus.resp_valid = err_ph_q;
        bus.resp_err   = err_ph_q;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Randomized self-checking bench for ahb_master_bridge with a transaction-level reference model.
module tb_ahb_master_bridge;
  import ahb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ahb_master_bridge_if bus();
  ahb_master_bridge dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic idle_inputs();
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_fetch = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_size = 3'd0; bus.req_signed = 1'b0;
    bus.instruction = 32'd0; bus.load_out = 32'd0;
    bus.hready_inst = 1'b1; bus.hready_data = 1'b1; bus.hresp_inst = 1'b0; bus.hresp_data = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_rv"}, 32'(bus.resp_valid), 32'd0);
    check_val({tag, "_htrans"}, 32'(bus.htrans), 32'd0);
    check_val({tag, "_hsel"}, {30'd0, bus.HSEL1, bus.HSEL2}, 32'd0);
    check_val({tag, "_haddr"}, bus.haddr, 32'd0);
  endtask

  // One request from the core; w = wait states, hr = slave error response.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic fe, input logic [2:0] sz,
                         input logic sg, input logic [31:0] wd, input int w, input logic hr,
                         input logic [31:0] rom_d, input logic [31:0] ram_d, input logic hold);
    logic rom, ram, mis, ew, err;
    logic [31:0] src, exp_rd, exp_wd;
    int c, exp_c;
    rom = (addr < 32'h0000_1000);
    ram = (addr >= 32'h1000_0000) && (addr < 32'h1000_1000);
    mis = (sz == 3'd1 && addr[0]) || (sz == 3'd2 && addr[1:0] != 2'b00);
    ew  = wr && !fe;
    err = !(rom || ram) || mis || (rom && ew);
    src = (rom ? rom_d : ram_d) >> (8 * addr[1:0]);
    if (sz == 3'd0) exp_rd = (sg && src[7]) ? (src | 32'hFFFF_FF00) : (src & 32'h0000_00FF);
    else if (sz == 3'd1) exp_rd = (sg && src[15]) ? (src | 32'hFFFF_0000) : (src & 32'h0000_FFFF);
    else exp_rd = src;
    if (err || ew || hr) exp_rd = 32'd0;
    if (sz == 3'd0) exp_wd = (wd & 32'hFF) * 32'h0101_0101;
    else if (sz == 3'd1) exp_wd = (wd & 32'hFFFF) * 32'h0001_0001;
    else exp_wd = wd;
    exp_c = err ? 1 : 2 + w;

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_fetch = fe; bus.req_addr = addr;
    bus.req_wdata = wd; bus.req_size = sz; bus.req_signed = sg;
    bus.instruction = rom_d; bus.load_out = ram_d;
    // The unselected slave looks ready with the opposite response, so a wrong select shows up.
    bus.hready_inst = rom ? (w == 0) : 1'b1;
    bus.hready_data = rom ? 1'b1 : (w == 0);
    bus.hresp_inst  = rom ? hr : ~hr;
    bus.hresp_data  = rom ? ~hr : hr;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
    check_val("accept_busy", 32'(bus.busy), 32'd1);
    if (err) begin
      check_val("err_htrans", 32'(bus.htrans), 32'd0);
      check_val("err_hsel", {30'd0, bus.HSEL1, bus.HSEL2}, 32'd0);
      check_val("err_early_rv", 32'(bus.resp_valid), 32'd0);
    end else begin
      check_val("addr_htrans", 32'(bus.htrans), 32'h2);
      check_val("addr_hsel", {30'd0, bus.HSEL1, bus.HSEL2}, {30'd0, rom, ram});
      check_val("addr_haddr", bus.haddr, addr);
      check_val("addr_hprot", 32'(bus.hprot), {28'd0, 3'b001, ~fe});
      check_val("addr_hwrite", 32'(bus.hwrite), 32'(ew));
      check_val("addr_hsize", 32'(bus.hsize), 32'(sz));
    end
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
      if (!err && c == 1) begin
        check_val("data_htrans", 32'(bus.htrans), 32'd0);
        check_val("data_haddr", bus.haddr, addr);
        if (ew) check_val("data_hwdata", bus.hwdata, exp_wd);
      end
      if (c == w + 1) begin
        bus.hready_inst = 1'b1; bus.hready_data = 1'b1;
      end
    end while (!bus.resp_valid && c < 40);
    check_val("latency", 32'(c), 32'(exp_c));
    check_val("resp_valid", 32'(bus.resp_valid), 32'd1);
    check_val("resp_err", 32'(bus.resp_err), 32'(err || hr));
    check_val("resp_rdata", bus.resp_rdata, exp_rd);
    check_val("resp_busy", 32'(bus.busy), 32'd0);
    check_val("resp_hsel", {30'd0, bus.HSEL1, bus.HSEL2}, 32'd0);
    @(posedge clk); #1;
    check_val("pulse_end", 32'(bus.resp_valid), 32'd0);
    check_val("no_accept_resp", 32'(bus.busy), 32'd0);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] a, base, off;
    logic [2:0] sz;
    int region;
    idle_inputs();
    reset = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // Directed cases.
    run_txn(32'h0000_0010, 1'b0, 1'b1, 3'd2, 1'b0, 32'd0, 0, 1'b0, 32'h0051_0513, 32'hDEAD_BEEF, 1'b0);
    run_txn(32'h1000_0003, 1'b0, 1'b0, 3'd0, 1'b1, 32'd0, 0, 1'b0, 32'h0, 32'h80AA_BBCC, 1'b0);
    run_txn(32'h1000_0003, 1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 0, 1'b0, 32'h0, 32'h80AA_BBCC, 1'b0);
    run_txn(32'h1000_0002, 1'b1, 1'b0, 3'd1, 1'b0, 32'h0000_1234, 0, 1'b0, 32'h0, 32'h0, 1'b0);
    run_txn(32'h2000_0000, 1'b0, 1'b0, 3'd2, 1'b0, 32'd0, 0, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    run_txn(32'h1000_0001, 1'b0, 1'b0, 3'd2, 1'b0, 32'd0, 0, 1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0);
    run_txn(32'h1000_0010, 1'b0, 1'b0, 3'd2, 1'b0, 32'd0, 3, 1'b1, 32'h0, 32'h3333_4444, 1'b0);
    run_txn(32'h0000_0020, 1'b1, 1'b0, 3'd2, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 32'h0, 32'h0, 1'b1);
    run_txn(32'h1000_0FFE, 1'b0, 1'b0, 3'd1, 1'b1, 32'd0, 1, 1'b0, 32'h0, 32'h9876_5432, 1'b1);

    // Reset during DATA aborts the transfer.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_fetch = 1'b0; bus.req_addr = 32'h1000_0004;
    bus.req_size = 3'd2; bus.hready_data = 1'b0;
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk); reset = 1'b0; bus.hready_data = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_reset");
    run_txn(32'h1000_0008, 1'b0, 1'b0, 3'd2, 1'b0, 32'd0, 0, 1'b0, 32'h0, 32'h5A5A_A5A5, 1'b0);

    // Randomized traffic around the window edges.
    for (int i = 0; i < 150; i++) begin
      region = $urandom_range(0, 4);
      case (region)
        0: base = 32'h0000_0000;
        1, 2: base = 32'h1000_0000;
        3: base = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h1000_1000;
        default: base = 32'h2000_0000;
      endcase
      sz = 3'($urandom_range(0, 2));
      off = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 3'd1) off = off & 32'hFFFF_FFFE;
        else if (sz == 3'd2) off = off & 32'hFFFF_FFFC;
      end
      a = base + off;
      run_txn(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), sz,
              1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3),
              1'($urandom_range(0, 5) == 0), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
